// File: rtl/counter_pkg.sv
// rtl/counter_pkg.sv - shared direction constants and next-count helper for the modulo counter
package counter_pkg;

    localparam logic DIR_DOWN = 1'b0;
    localparam logic DIR_UP   = 1'b1;

    // Next count value for one step inside 0..max_val.
    // Values are carried at 32 bits so any legal WIDTH (2..32) fits; callers truncate.
    // At a range end the count wraps to the opposite end, or holds when sat is set.
    function automatic logic [31:0] next_count(
        input logic [31:0] cur,
        input logic        dir,
        input logic [31:0] max_val,
        input logic        sat
    );
        logic [31:0] result;
        result = cur;
        if (dir == DIR_UP) begin
            if (cur >= max_val) begin
                result = sat ? max_val : 32'd0;
            end else begin
                result = cur + 32'd1;
            end
        end else begin
            if (cur == 32'd0) begin
                result = sat ? 32'd0 : max_val;
            end else if (cur > max_val) begin
                result = max_val;
            end else begin
                result = cur - 32'd1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/counter_prescaler.sv
// rtl/counter_prescaler.sv - enabled-cycle divider producing one step tick every PRESCALE enabled cycles
module counter_prescaler #(
    parameter int PRESCALE = 1
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_en,
    input  logic i_clr,
    output logic o_tick
);

    localparam int              PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PS_W-1:0] LAST = PS_W'(PRESCALE - 1);

    logic [PS_W-1:0] r_div;
    logic            w_last;

    assign w_last = (r_div == LAST);
    assign o_tick = w_last;

    // Count enabled cycles 0..PRESCALE-1; a load restarts the phase, en=0 freezes it.
    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr) begin
            r_div <= '0;
        end else if (i_en) begin
            if (w_last) begin
                r_div <= '0;
            end else begin
                r_div <= r_div + 1'b1;
            end
        end
    end

endmodule

// File: rtl/counter.sv
// rtl/counter.sv - parameterised modulo up/down counter with terminal count and sticky wrap; optional prescaler under COUNTER_PRESCALE_EN
module counter
    import counter_pkg::*;
#(
    parameter int               WIDTH    = 4,
    parameter logic [WIDTH-1:0] MAX_VAL  = {WIDTH{1'b1}},
    parameter int               SATURATE = 0,
    parameter int               PRESCALE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up_dn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             clr_wrap,
    output logic [WIDTH-1:0] cnt,
    output logic             tc,
    output logic             wrapped
);

    logic [WIDTH-1:0] r_cnt;
    logic             r_wrapped;
    logic             w_qual;
    logic             w_step;
    logic             w_at_end;
    logic             w_tc;
    logic [WIDTH-1:0] w_next;
    logic [WIDTH-1:0] w_load_clamped;

`ifdef COUNTER_PRESCALE_EN
    counter_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .i_clk  (clk),
        .i_rst  (rst),
        .i_en   (en),
        .i_clr  (load),
        .o_tick (w_qual)
    );
`else
    assign w_qual = 1'b1;
`endif

    assign w_step   = en & ~load & w_qual;
    assign w_at_end = (up_dn == DIR_UP) ? (r_cnt == MAX_VAL) : (r_cnt == '0);
    assign w_tc     = w_step & w_at_end;

    assign cnt     = r_cnt;
    assign tc      = w_tc;
    assign wrapped = r_wrapped;

    // Next step value and range-clamped load value.
    always_comb begin
        w_next         = WIDTH'(next_count(32'(r_cnt), up_dn, 32'(MAX_VAL), SATURATE != 0));
        w_load_clamped = (load_val > MAX_VAL) ? MAX_VAL : load_val;
    end

    // Count register: reset, then load, then step, otherwise hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (load) begin
            r_cnt <= w_load_clamped;
        end else if (w_step) begin
            r_cnt <= w_next;
        end
    end

    // Sticky wrap flag: a real wrap sets it and beats a simultaneous clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wrapped <= 1'b0;
        end else if (w_tc && (SATURATE == 0)) begin
            r_wrapped <= 1'b1;
        end else if (clr_wrap) begin
            r_wrapped <= 1'b0;
        end
    end

endmodule

// File: tb/tb_counter.sv
// tb/tb_counter.sv - directed self-checking bench for counter (default, MAX_VAL=9, SATURATE=1, prescale under COUNTER_PRESCALE_EN)
module tb_counter;

    logic       clk;
    logic       rst;
    logic       en;
    logic       up_dn;
    logic       load;
    logic [3:0] load_val;
    logic       clr_wrap;

    logic [3:0] cnt_d, cnt_m, cnt_s;
    logic       tc_d, tc_m, tc_s;
    logic       wr_d, wr_m, wr_s;

    int checks;
    int failures;

    counter u_def (
        .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .load(load),
        .load_val(load_val), .clr_wrap(clr_wrap),
        .cnt(cnt_d), .tc(tc_d), .wrapped(wr_d)
    );

    counter #(.WIDTH(4), .MAX_VAL(4'd9)) u_m9 (
        .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .load(load),
        .load_val(load_val), .clr_wrap(clr_wrap),
        .cnt(cnt_m), .tc(tc_m), .wrapped(wr_m)
    );

    counter #(.WIDTH(4), .SATURATE(1)) u_sat (
        .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .load(load),
        .load_val(load_val), .clr_wrap(clr_wrap),
        .cnt(cnt_s), .tc(tc_s), .wrapped(wr_s)
    );

`ifdef COUNTER_PRESCALE_EN
    logic [3:0] cnt_p;
    logic       tc_p;
    logic       wr_p;

    counter #(.WIDTH(4), .PRESCALE(3)) u_ps (
        .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .load(load),
        .load_val(load_val), .clr_wrap(clr_wrap),
        .cnt(cnt_p), .tc(tc_p), .wrapped(wr_p)
    );
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        rst      = 1'b0;
        en       = 1'b0;
        up_dn    = 1'b1;
        load     = 1'b0;
        load_val = 4'd0;
        clr_wrap = 1'b0;
    endtask

    task automatic do_reset;
        idle_inputs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset;
        idle_inputs();
        rst      = 1'b1;
        load     = 1'b1;
        load_val = 4'd7;
        en       = 1'b1;
        tick();
        idle_inputs();
        #1;
        checks++;
        if (cnt_d !== 4'd0) begin
            failures++;
            $display("FAIL reset_cnt got=%0d want=0", cnt_d);
        end
        checks++;
        if (wr_d !== 1'b0) begin
            failures++;
            $display("FAIL reset_wrapped got=%b want=0", wr_d);
        end
        checks++;
        if (tc_d !== 1'b0) begin
            failures++;
            $display("FAIL reset_tc got=%b want=0", tc_d);
        end
    endtask

    task automatic test_up_wrap;
        logic [3:0] exp_cnt;
        do_reset();
        en    = 1'b1;
        up_dn = 1'b1;
        for (int i = 0; i < 20; i++) begin
            #1;
            exp_cnt = 4'(i % 16);
            checks++;
            if (cnt_d !== exp_cnt) begin
                failures++;
                $display("FAIL up_cnt[%0d] got=%0d want=%0d", i, cnt_d, exp_cnt);
            end
            checks++;
            if (tc_d !== (exp_cnt == 4'd15)) begin
                failures++;
                $display("FAIL up_tc[%0d] got=%b want=%b", i, tc_d, (exp_cnt == 4'd15));
            end
            checks++;
            if (wr_d !== (i >= 16)) begin
                failures++;
                $display("FAIL up_wrapped[%0d] got=%b want=%b", i, wr_d, (i >= 16));
            end
            tick();
        end
    endtask

    task automatic test_down_wrap_m9;
        logic [3:0] exp_seq [5];
        exp_seq = '{4'd2, 4'd1, 4'd0, 4'd9, 4'd8};
        do_reset();
        load     = 1'b1;
        load_val = 4'd2;
        tick();
        load  = 1'b0;
        en    = 1'b1;
        up_dn = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++;
            if (cnt_m !== exp_seq[i]) begin
                failures++;
                $display("FAIL down_cnt[%0d] got=%0d want=%0d", i, cnt_m, exp_seq[i]);
            end
            checks++;
            if (tc_m !== (exp_seq[i] == 4'd0)) begin
                failures++;
                $display("FAIL down_tc[%0d] got=%b want=%b", i, tc_m, (exp_seq[i] == 4'd0));
            end
            checks++;
            if (wr_m !== (i >= 3)) begin
                failures++;
                $display("FAIL down_wrapped[%0d] got=%b want=%b", i, wr_m, (i >= 3));
            end
            tick();
        end
    endtask

    task automatic test_saturate;
        logic [3:0] exp_seq [4];
        exp_seq = '{4'd14, 4'd15, 4'd15, 4'd15};
        do_reset();
        load     = 1'b1;
        load_val = 4'd14;
        tick();
        load  = 1'b0;
        en    = 1'b1;
        up_dn = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++;
            if (cnt_s !== exp_seq[i]) begin
                failures++;
                $display("FAIL sat_cnt[%0d] got=%0d want=%0d", i, cnt_s, exp_seq[i]);
            end
            checks++;
            if (tc_s !== (exp_seq[i] == 4'd15)) begin
                failures++;
                $display("FAIL sat_tc[%0d] got=%b want=%b", i, tc_s, (exp_seq[i] == 4'd15));
            end
            checks++;
            if (wr_s !== 1'b0) begin
                failures++;
                $display("FAIL sat_wrapped[%0d] got=%b want=0", i, wr_s);
            end
            tick();
        end
        up_dn = 1'b0;
        load  = 1'b1;
        load_val = 4'd0;
        tick();
        load = 1'b0;
        tick();
        #1;
        checks++;
        if (cnt_s !== 4'd0) begin
            failures++;
            $display("FAIL sat_down_hold got=%0d want=0", cnt_s);
        end
    endtask

    task automatic test_priority;
        do_reset();
        en       = 1'b0;
        load     = 1'b1;
        load_val = 4'd12;
        tick();
        load = 1'b0;
        #1;
        checks++;
        if (cnt_m !== 4'd9) begin
            failures++;
            $display("FAIL load_clamp got=%0d want=9", cnt_m);
        end
        checks++;
        if (cnt_d !== 4'd12) begin
            failures++;
            $display("FAIL load_noclamp got=%0d want=12", cnt_d);
        end
        for (int i = 0; i < 3; i++) tick();
        checks++;
        if (cnt_m !== 4'd9 || tc_m !== 1'b0) begin
            failures++;
            $display("FAIL hold got=%0d/%b want=9/0", cnt_m, tc_m);
        end
        load     = 1'b1;
        load_val = 4'd15;
        tick();
        en       = 1'b1;
        up_dn    = 1'b1;
        load_val = 4'd3;
        #1;
        checks++;
        if (tc_d !== 1'b0) begin
            failures++;
            $display("FAIL load_masks_tc got=%b want=0", tc_d);
        end
        tick();
        load = 1'b0;
        #1;
        checks++;
        if (cnt_d !== 4'd3 || wr_d !== 1'b0) begin
            failures++;
            $display("FAIL load_over_step got=%0d/%b want=3/0", cnt_d, wr_d);
        end
    endtask

    task automatic test_direction;
        logic [3:0] exp_seq [4];
        logic       dir_seq [4];
        exp_seq = '{4'd6, 4'd7, 4'd6, 4'd5};
        dir_seq = '{1'b1, 1'b1, 1'b0, 1'b0};
        do_reset();
        load     = 1'b1;
        load_val = 4'd5;
        tick();
        load = 1'b0;
        en   = 1'b1;
        for (int i = 0; i < 4; i++) begin
            up_dn = dir_seq[i];
            tick();
            checks++;
            if (cnt_d !== exp_seq[i]) begin
                failures++;
                $display("FAIL dir_cnt[%0d] got=%0d want=%0d", i, cnt_d, exp_seq[i]);
            end
        end
    endtask

    task automatic test_sticky;
        do_reset();
        load     = 1'b1;
        load_val = 4'd15;
        tick();
        load     = 1'b0;
        en       = 1'b1;
        up_dn    = 1'b1;
        clr_wrap = 1'b1;
        tick();
        checks++;
        if (cnt_d !== 4'd0 || wr_d !== 1'b1) begin
            failures++;
            $display("FAIL sticky_set_wins got=%0d/%b want=0/1", cnt_d, wr_d);
        end
        en = 1'b0;
        tick();
        checks++;
        if (wr_d !== 1'b0) begin
            failures++;
            $display("FAIL sticky_clear got=%b want=0", wr_d);
        end
        clr_wrap = 1'b0;
    endtask

`ifdef COUNTER_PRESCALE_EN
    task automatic test_prescale;
        logic [3:0] exp_cnt;
        logic       en_seq  [7];
        logic [3:0] gap_exp [7];
        do_reset();
        en    = 1'b1;
        up_dn = 1'b1;
        for (int c = 1; c <= 9; c++) begin
            tick();
            exp_cnt = 4'(c / 3);
            checks++;
            if (cnt_p !== exp_cnt) begin
                failures++;
                $display("FAIL ps_cnt[%0d] got=%0d want=%0d", c, cnt_p, exp_cnt);
            end
        end
        en_seq  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        gap_exp = '{4'd0, 4'd0, 4'd0, 4'd0, 4'd1, 4'd1, 4'd1};
        do_reset();
        up_dn = 1'b1;
        for (int c = 0; c < 7; c++) begin
            en = en_seq[c];
            tick();
            checks++;
            if (cnt_p !== gap_exp[c]) begin
                failures++;
                $display("FAIL ps_gap_cnt[%0d] got=%0d want=%0d", c + 1, cnt_p, gap_exp[c]);
            end
        end
    endtask
`endif

    initial begin
        checks   = 0;
        failures = 0;
        idle_inputs();
        test_reset();
        test_up_wrap();
        test_down_wrap_m9();
        test_saturate();
        test_priority();
        test_direction();
        test_sticky();
`ifdef COUNTER_PRESCALE_EN
        test_prescale();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
